// File: rtl/hash_pkg.sv
// hash_pkg: constants shared between hash_gen and hash_arb, and the arbiter FSM state type.
// Ports: none (package).
package hash_pkg;
    localparam int HASH_W          = 128;
    localparam int BIT_BLOCK_START = 9;
    localparam int BIT_BLOCK_END   = 8;
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/hash_arb_if.sv
// hash_arb_if: requester, hash_gen and result signals between packet sources and hash_arb.
// Ports: none; modport slave is the arbiter side, master is the source/hash_gen side.
interface hash_arb_if #(
    parameter int N_REQ = 4
);
    import hash_pkg::*;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ*HASH_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [HASH_W-1:0]       hg_data_o;
    logic                    hg_valid_o;
    logic [HASH_W-1:0]       hg_res_data_i;
    logic                    hg_res_valid_i;
    logic [HASH_W-1:0]       res_data_o;
    logic [N_REQ-1:0]        res_valid_o;
    modport slave (
        input  req_valid_i, req_data_i, hg_res_data_i, hg_res_valid_i,
        output req_ready_o, hg_data_o, hg_valid_o, res_data_o, res_valid_o
    );
    modport master (
        output req_valid_i, req_data_i, hg_res_data_i, hg_res_valid_i,
        input  req_ready_o, hg_data_o, hg_valid_o, res_data_o, res_valid_o
    );
endinterface

// File: rtl/hash_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr_i (wrapping).
// Ports: req_i request vector, ptr_i start index, idx_o winner index, found_o any request set.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    logic [2*N-1:0] rot;
    logic [W-1:0]   off;
    logic [W:0]     sum;
    // Rotating the doubled vector right by ptr_i puts the pointer position at bit 0.
    assign rot     = {req_i, req_i} >> ptr_i;
    assign found_o = |req_i;
    assign sum     = {1'b0, ptr_i} + {1'b0, off};
    assign idx_o   = W'((sum >= (W+1)'(N)) ? sum - (W+1)'(N) : sum);
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) off = rot[i] ? W'(i) : off;
    end
endmodule

// File: rtl/hash_arb.sv
// hash_arb: block-atomic round-robin arbiter sharing one hash_gen between N_REQ requesters.
// Ports: clk; rst (sync, active-high); bus (hash_arb_if.slave: requester valid/data/ready,
//   hash_gen word/valid out, hash_gen result in, routed result out); busy_o block in progress;
//   owner_o current or last owner; err_o sticky timeout flag.
// Optional: HASH_ARB_TIMEOUT_EN releases an owner stalled TIMEOUT_CYC cycles mid-block.
module hash_arb
    import hash_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int BIT_BLOCK_START = hash_pkg::BIT_BLOCK_START,
    parameter int BIT_BLOCK_END   = hash_pkg::BIT_BLOCK_END,
    parameter int TIMEOUT_CYC     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    hash_arb_if.slave                  bus,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic                       err_o
);
    localparam int OW = $clog2(N_REQ);
    arb_state_e        state_q, state_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, tag_q, tag_d, pick_idx, next_ptr;
    logic [HASH_W-1:0] hg_data_q, hg_data_d, own_word;
    logic              hg_valid_q, hg_valid_d, tag_valid_q, tag_valid_d;
    logic              pick_found, locked, xfer, rel_blk, timeout, tag_set;
    logic [N_REQ-1:0]  start_vec, own_oh;

    always_comb begin
        start_vec = '0;
        own_word  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            start_vec[i] = bus.req_valid_i[i] & bus.req_data_i[HASH_W*i+BIT_BLOCK_START];
            own_word     = (owner_q == OW'(i)) ? bus.req_data_i[HASH_W*i +: HASH_W] : own_word;
        end
    end

    rr_pick #(.N(N_REQ), .W(OW)) u_pick (
        .req_i   (start_vec),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign locked   = state_q == LOCKED;
    assign own_oh   = N_REQ'(1) << owner_q;
    assign xfer     = locked & |(own_oh & bus.req_valid_i);
    assign next_ptr = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign rel_blk  = (xfer & own_word[BIT_BLOCK_END]) | timeout;
    // The end word leaving on hg_data_o is the one hash_gen answers next cycle; owner_q
    // still names its requester because re-arbitration updates owner on this same edge.
    assign tag_set  = hg_valid_q & hg_data_q[BIT_BLOCK_END];

    always_comb begin
        state_d     = locked ? (rel_blk ? IDLE : LOCKED) : (pick_found ? LOCKED : IDLE);
        owner_d     = (!locked && pick_found) ? pick_idx : owner_q;
        rr_ptr_d    = rel_blk ? next_ptr : rr_ptr_q;
        hg_valid_d  = xfer;
        hg_data_d   = xfer ? own_word : hg_data_q;
        tag_d       = tag_set ? owner_q : tag_q;
        tag_valid_d = tag_set | (tag_valid_q & ~bus.hg_res_valid_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            hg_data_q   <= '0;
            hg_valid_q  <= 1'b0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            hg_data_q   <= hg_data_d;
            hg_valid_q  <= hg_valid_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
        end
    end

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
    // The TIMEOUT_CYC-th consecutive cycle without a transfer is the releasing cycle.
    assign timeout = locked & ~xfer & (stall_q == CW'(TIMEOUT_CYC - 1));
    always_comb begin
        stall_d = (!locked || xfer || timeout) ? '0 : stall_q + 1'b1;
        err_d   = err_q | timeout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
    assign err_o = err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign bus.req_ready_o = locked ? own_oh : '0;
    assign bus.hg_data_o   = hg_data_q;
    assign bus.hg_valid_o  = hg_valid_q;
    assign bus.res_data_o  = bus.hg_res_data_i;
    assign bus.res_valid_o = (bus.hg_res_valid_i & tag_valid_q) ? N_REQ'(1) << tag_q : '0;
    assign busy_o          = locked;
    assign owner_o         = owner_q;
endmodule

// File: tb/tb_hash_arb.sv
// tb_hash_arb: randomized and directed checks of hash_arb against a behavioural model.
module tb_hash_arb;
    import hash_pkg::*;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam logic [127:0] ST = 128'(1) << BIT_BLOCK_START;
    localparam logic [127:0] EN = 128'(1) << BIT_BLOCK_END;

    logic clk = 1'b0, rst = 1'b1, rst_req = 1'b1, spur = 1'b0, spur_req = 1'b0;
    logic busy, err;
    logic [1:0] owner;
    always #5 clk = ~clk;

    hash_arb_if #(.N_REQ(N)) bus ();
    hash_arb #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .owner_o(owner), .err_o(err)
    );

    function automatic logic [127:0] rotl1(input logic [127:0] x);
        return {x[126:0], x[127]};
    endfunction
    function automatic logic [127:0] hstep(input logic [127:0] h, input logic [127:0] w);
        return w[BIT_BLOCK_START] ? w : w ^ rotl1(h);
    endfunction

    // hash_gen stand-in: one-cycle result after the end word, no reset.
    logic [127:0] hg_h = '0, hg_rd = '0;
    logic hg_rv = 1'b0;
    always @(posedge clk) begin
        if (bus.hg_valid_o) hg_h <= hstep(hg_h, bus.hg_data_o);
        hg_rv <= (bus.hg_valid_o && bus.hg_data_o[BIT_BLOCK_END]) || spur;
        hg_rd <= bus.hg_valid_o ? hstep(hg_h, bus.hg_data_o) : 128'hdead;
    end
    assign bus.hg_res_valid_i = hg_rv;
    assign bus.hg_res_data_i  = hg_rd;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Source queues and stimulus controls
    logic [127:0] q[N][$];
    logic [N-1:0] hold_off = '0;
    int vprob = 100;

    // Behavioural model
    bit m_busy = 0, m_hv = 0, m_err = 0;
    int m_owner = 0, m_ptr = 0, m_cd = 0, m_res_own = 0, m_stall = 0;
    logic [127:0] m_hd = '0, m_h = '0, m_res_h = '0;

    // Observations for literal checks
    int cyc = 0, hg_cnt = 0;
    bit prev_busy = 0;
    int grants[$], grant_cyc[$];
    logic [N-1:0] res_order[$];
    logic [127:0] last_res_d = '0;

    task automatic clear_obs();
        grants.delete(); grant_cyc.delete(); res_order.delete(); hg_cnt = 0;
    endtask

    task automatic cycle();
        logic [N-1:0] v;
        logic [127:0] dw[N];
        logic [127:0] w;
        logic [N-1:0] exp_rv;
        bit x;
        @(negedge clk);
        cyc++;
        exp_rv = (m_cd == 1) ? N'(1) << m_res_own : N'(0);
        chk("req_ready", bus.req_ready_o, m_busy ? N'(1) << m_owner : N'(0));
        chk("busy", busy, m_busy);
        chk("owner", owner, m_owner);
        chk("hg_valid", bus.hg_valid_o, m_hv);
        if (m_hv) chk("hg_data", bus.hg_data_o, m_hd);
        chk("res_valid", bus.res_valid_o, exp_rv);
        if (m_cd == 1) chk("res_data", bus.res_data_o, m_res_h);
        chk("err", err, m_err);
        if (bus.res_valid_o != 0) begin
            res_order.push_back(bus.res_valid_o);
            last_res_d = bus.res_data_o;
        end
        if (bus.hg_valid_o) hg_cnt++;
        if (busy && !prev_busy) begin
            grants.push_back(int'(owner));
            grant_cyc.push_back(cyc);
        end
        prev_busy = busy;
        rst  = rst_req;
        spur = spur_req;
        for (int i = 0; i < N; i++) begin
            v[i]  = q[i].size() > 0 && !hold_off[i] && ($urandom_range(99) < vprob);
            dw[i] = q[i].size() > 0 ? q[i][0] : {$urandom, $urandom, $urandom, $urandom};
            bus.req_valid_i[i] = v[i];
            bus.req_data_i[128*i +: 128] = dw[i];
        end
        if (rst_req) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hv = 0; m_hd = '0;
            m_cd = 0; m_err = 0; m_stall = 0;
        end else begin
            if (m_cd > 0) m_cd--;
            x = m_busy && v[m_owner];
            w = dw[m_owner];
            m_hv = x;
            if (x) begin
                void'(q[m_owner].pop_front());
                m_hd = w;
                m_h  = hstep(m_h, w);
                if (w[BIT_BLOCK_END]) begin
                    m_cd = 2; m_res_own = m_owner; m_res_h = m_h;
                end
            end
            if (m_busy) begin
                m_stall = x ? 0 : m_stall + 1;
                if (x && w[BIT_BLOCK_END]) begin
                    m_busy = 0; m_ptr = (m_owner + 1) % N;
                end
`ifdef HASH_ARB_TIMEOUT_EN
                else if (m_stall == TO) begin
                    m_busy = 0; m_ptr = (m_owner + 1) % N; m_err = 1;
                end
`endif
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c = (m_ptr + k) % N;
                    if (!m_busy && v[c] && dw[c][BIT_BLOCK_START]) begin
                        m_owner = c; m_busy = 1; m_stall = 0;
                    end
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst_req = 1; hold_off = '0;
        for (int i = 0; i < N; i++) q[i].delete();
        run(2);
        rst_req = 0;
        clear_obs();
    endtask

    function automatic bit pending();
        bit p = m_busy || m_cd != 0;
        for (int i = 0; i < N; i++) p |= q[i].size() > 0;
        return p;
    endfunction

    task automatic drain(input int lim);
        int n = 0;
        while (pending() && n < lim) begin
            cycle();
            n++;
        end
        chk("drain_done", n < lim, 1);
    endtask

    task automatic add_block(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            logic [127:0] w = {$urandom, $urandom, $urandom, $urandom};
            w[BIT_BLOCK_END]   = (k == len - 1);
            w[BIT_BLOCK_START] = (k == 0) ? 1'b1 : ($urandom_range(7) == 0);
            q[r].push_back(w);
        end
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_hg_data", bus.hg_data_o, 0);
        chk("rst_hg_valid", bus.hg_valid_o, 0);
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        // Three-word block from requester 0: A=start, B=0, C=end
        q[0].push_back(ST); q[0].push_back(128'h0); q[0].push_back(EN);
        drain(50);
        chk("t1_hg_cycles", hg_cnt, 3);
        chk("t1_res_count", res_order.size(), 1);
        chk("t1_res_bit", res_order[0], 4'b0001);
        chk("t1_res_data", last_res_d, 128'h900);

        // Result pulse with no outstanding tag is dropped
        spur_req = 1; cycle(); spur_req = 0;
        run(3);
        chk("spur_dropped", res_order.size(), 1);

        // Requesters 0 and 2 contend; then 3 and 0 to expose rr_ptr=3
        do_reset();
        q[0].push_back(ST | 128'h11); q[0].push_back(EN | 128'h22); q[0].push_back(ST | EN | 128'h33);
        q[2].push_back(ST | 128'h44); q[2].push_back(EN | 128'h55);
        q[3].push_back(ST | EN | 128'h66);
        drain(100);
        chk("t2_ngrants", grants.size(), 4);
        chk("t2_g0", grants[0], 0);
        chk("t2_g1", grants[1], 2);
        chk("t2_g2", grants[2], 3);
        chk("t2_g3", grants[3], 0);
        chk("t2_gap", grant_cyc[1] - grant_cyc[0], 3);

        // Owner 1 stalls 5 cycles while requester 3 waits with a start word
        do_reset();
        q[1].push_back(ST | 128'hA1); q[1].push_back(128'hA2); q[1].push_back(EN | 128'hA3);
        q[3].push_back(ST | EN | 128'hB1);
        run(2);
        hold_off[1] = 1;
        run(5);
        #1;
        chk("t3_ready", bus.req_ready_o, 4'b0010);
        chk("t3_owner", owner, 1);
        hold_off[1] = 0;
        drain(100);
        chk("t3_order", grants[1], 3);

        // Back-to-back single-word blocks from 0..3
        do_reset();
        for (int i = 0; i < N; i++) q[i].push_back(ST | EN | 128'(i * 7 + 1));
        drain(100);
        chk("t4_nres", res_order.size(), 4);
        for (int i = 0; i < 4; i++) chk("t4_res_order", res_order[i], N'(1) << i);
        for (int i = 1; i < 4; i++) chk("t4_grant_gap", grant_cyc[i] - grant_cyc[i-1], 2);

        // Reset with an end word tagged and its result in flight
        do_reset();
        q[0].push_back(ST | 128'hC1); q[0].push_back(EN | 128'hC2);
        q[1].push_back(ST | 128'hD1); q[1].push_back(128'hD2); q[1].push_back(EN | 128'hD3);
        run(3);
        rst_req = 1; cycle(); rst_req = 0;
        #1;
        chk("t5_inflight_seen", bus.hg_res_valid_i, 1);
        chk("t5_res_valid", bus.res_valid_o, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", bus.req_ready_o, 0);
        clear_obs();
        q[2].push_back(ST | 128'hE1); q[2].push_back(EN | 128'hE2);
        drain(100);
        chk("t5_nres", res_order.size(), 2);

        // Owner stalls past the timeout window
        do_reset();
        q[1].push_back(ST | 128'hF1); q[1].push_back(128'hF2); q[1].push_back(EN | 128'hF3);
        q[2].push_back(ST | EN | 128'hF4);
        run(2);
        hold_off[1] = 1;
        run(12);
        #1;
`ifdef HASH_ARB_TIMEOUT_EN
        chk("t6_err", err, 1);
        chk("t6_next_owner", grants[1], 2);
        do_reset();
`else
        chk("t6_err", err, 0);
        chk("t6_busy", busy, 1);
        chk("t6_owner", owner, 1);
        hold_off[1] = 0;
        drain(100);
`endif

        // Randomized traffic
        do_reset();
        vprob = 85;
        for (int r = 0; r < N; r++)
            for (int b = 0; b < 25; b++) add_block(r, $urandom_range(1, 4));
        drain(5000);
        chk("rand_nres", res_order.size(), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
